regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised register file: NREGS registers of DATA_W bits, one synchronous write port, two independent registered read ports (A, B).
- Write select comes from a binary-to-one-hot decoder; each read port uses an NREGS-way one-hot mux.
- Each read port has 1-cycle latency, a valid strobe and write-first bypass.
- Drop-in successor to the 8x16 single-read lab register file; feeds the datapath's ALU operand registers.

Parameters:
DATA_W, 16, width of each register and data buses
ADDR_W, 3, register address width
NREGS, 1<<ADDR_W, register count; must be <= 2**ADDR_W; addresses >= NREGS are out of range

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-high; sampled on rising clk edge
write  input  1  write enable
writenum  input  ADDR_W  write address
data_in  input  DATA_W  write data
rd_en_a  input  1  read request, port A
readnum_a  input  ADDR_W  read address, port A
data_out_a  output  DATA_W  registered read data, port A
valid_a  output  1  one-cycle strobe: data_out_a updated this cycle
rd_en_b  input  1  read request, port B
readnum_b  input  ADDR_W  read address, port B
data_out_b  output  DATA_W  registered read data, port B
valid_b  output  1  one-cycle strobe, port B
addr_err  output  1  registered; set for one cycle when any enabled access used an address >= NREGS

Behaviour:
- Reset (edge where reset=1): all registers, data_out_a/b <= 0; valid_a/b, addr_err <= 0. Reset overrides a write or read in the same cycle. Reset mid-read kills the pending valid.
- Write: at the edge with write=1 and writenum < NREGS, R[writenum] <= data_in. Other registers hold. write=1 with writenum >= NREGS: no register changes; addr_err=1 next cycle.
- Read, per port, independent: at edge N with rd_en=1, data_out <= R[readnum] and valid=1 during cycle N+1. With rd_en=0, data_out holds its last value and valid=0.
- Bypass (write-first): if write=1, writenum==readnum and rd_en=1 at the same edge, data_out <= data_in, not the old contents.
- Both ports may read the same address in the same cycle; both return identical data.
- Out-of-range read: data_out <= 0, valid=1, addr_err=1 next cycle.
- Back-to-back reads every cycle: one result per cycle, no bubbles.
- Per-port state machine: IDLE (valid=0) and OUT (valid=1).
  - rd_en moves to OUT, or stays in OUT.
  - !rd_en moves to IDLE.
  - reset forces IDLE.
- No combinational path from any input to any output.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- When defined:
  - Each register stores an extra even-parity bit computed from data_in on write.
  - Added outputs parity_err_a and parity_err_b, registered and aligned with valid. Each is 1 when the stored parity does not match the stored data of the register read.
  - A bypassed read never flags an error.
  - Parity bits reset to 0.
- When undefined: no parity storage and no parity_err ports; all other behaviour is identical.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants; typedef reg_addr_t (ADDR_W bits); typedef reg_data_t (DATA_W bits); localparam RD_LATENCY=1.
- Sub-module vdff_load: DATA_W-wide register with load enable and synchronous reset. Instantiated once per register and once per read output.
- Decoder and mux logic is inlined, or reuses the existing parametrised Decoder.

Test Plan:
- Reset, then read all 8 addresses on A and B -> every data_out=0x0000, valid=1 one cycle after each request, addr_err=0.
- Write R3=0xABCD; next cycle read A=3, B=3 -> both 0xABCD one cycle later, valid_a=valid_b=1.
- Same edge: write R5=0x1234 and read A=5 (old R5=0) -> data_out_a=0x1234 (bypass). Next cycle read B=5 -> 0x1234.
- Stream rd_en_a=1 for 8 cycles with readnum_a=0..7, after writing R[i]=i*0x1111 -> outputs 0x0000..0x7777 in order, valid_a high 8 consecutive cycles.
- Write R2=0x00FF, then assert reset and read A=2 on the same edge -> valid_a=0 next cycle. Subsequent read of 2 -> 0x0000.
- NREGS=6: write addr 7 data 0xFFFF -> addr_err=1 next cycle, no register changed. Read addr 6 -> data_out=0, valid=1, addr_err=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the 2-read/1-write register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width
//   reg_addr_t / reg_data_t         : address and data types at the default sizes
//   RD_LATENCY                      : read-request to data_out latency, in cycles
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int RD_LATENCY     = 1;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/vdff_load.sv
// vdff_load: DATA_W-wide register with load enable and synchronous active-high reset.
// Used for every storage register and for each registered read output.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; clears q_o to zero
//   load_i : when high, q_o takes d_i at the next edge; otherwise q_o holds
//   d_i    : next value
//   q_o    : registered value
module vdff_load #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x DATA_W register file with one synchronous write port and
// two independent registered read ports (A, B), each with a valid strobe and
// write-first bypass. Addresses >= NREGS are out of range and raise addr_err.
// Optional build macro REGFILE_PARITY_EN adds a stored even-parity bit per
// register and the parity_err_a / parity_err_b outputs.
//   clk, reset                : clock, synchronous active-high reset
//   write, writenum, data_in  : write enable, address, data
//   rd_en_a, readnum_a        : port A read request and address
//   data_out_a, valid_a       : port A registered data and one-cycle valid
//   rd_en_b, readnum_b        : port B read request and address
//   data_out_b, valid_b       : port B registered data and one-cycle valid
//   addr_err                  : registered, any enabled access was out of range
//   parity_err_a/_b           : (REGFILE_PARITY_EN only) stored parity mismatch
import regfile_pkg::*;

module regfile_2r1w #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NREGS  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] readnum_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b,
  output logic              addr_err
`ifdef REGFILE_PARITY_EN
  ,
  output logic              parity_err_a,
  output logic              parity_err_b
`endif
);

`ifdef REGFILE_PARITY_EN
  localparam int STORE_W = DATA_W + 1;
`else
  localparam int STORE_W = DATA_W;
`endif

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OUT  = 1'b1;

  // One-hot decode; an out-of-range address yields all zeros, which both
  // suppresses the write and makes the read mux return zero.
  function automatic logic [NREGS-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [NREGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREGS; i++) begin
      oh[i] = (addr == ADDR_W'(i));
    end
    return oh;
  endfunction

  logic [NREGS-1:0]   wr_onehot;
  logic [NREGS-1:0]   sel_a;
  logic [NREGS-1:0]   sel_b;
  logic [STORE_W-1:0] wr_word;
  logic [STORE_W-1:0] regs_q [NREGS];
  logic [STORE_W-1:0] rd_word_a;
  logic [STORE_W-1:0] rd_word_b;
  logic               byp_a;
  logic               byp_b;
  logic [DATA_W-1:0]  rdata_a_d;
  logic [DATA_W-1:0]  rdata_b_d;
  logic [0:0]         state_a_q, state_a_d;
  logic [0:0]         state_b_q, state_b_d;
  logic               addr_err_q, addr_err_d;

  assign wr_onehot = write ? decode(writenum) : '0;
  assign sel_a     = decode(readnum_a);
  assign sel_b     = decode(readnum_b);

`ifdef REGFILE_PARITY_EN
  // Even parity: the stored bit makes the total count of ones even.
  assign wr_word = {^data_in, data_in};
`else
  assign wr_word = data_in;
`endif

  // Storage stage
  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    vdff_load #(.DATA_W(STORE_W)) u_reg (
      .clk    (clk),
      .reset  (reset),
      .load_i (wr_onehot[g]),
      .d_i    (wr_word),
      .q_o    (regs_q[g])
    );
  end

  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      rd_word_a = rd_word_a | ({STORE_W{sel_a[i]}} & regs_q[i]);
      rd_word_b = rd_word_b | ({STORE_W{sel_b[i]}} & regs_q[i]);
    end
  end

  // Write-first: a same-edge write to the address being read is forwarded.
  assign byp_a = write && (writenum == readnum_a) && (|sel_a);
  assign byp_b = write && (writenum == readnum_b) && (|sel_b);

  assign rdata_a_d = byp_a ? data_in : rd_word_a[DATA_W-1:0];
  assign rdata_b_d = byp_b ? data_in : rd_word_b[DATA_W-1:0];

  // Read output stage
  vdff_load #(.DATA_W(DATA_W)) u_out_a (
    .clk    (clk),
    .reset  (reset),
    .load_i (rd_en_a),
    .d_i    (rdata_a_d),
    .q_o    (data_out_a)
  );

  vdff_load #(.DATA_W(DATA_W)) u_out_b (
    .clk    (clk),
    .reset  (reset),
    .load_i (rd_en_b),
    .d_i    (rdata_b_d),
    .q_o    (data_out_b)
  );

  assign state_a_d  = rd_en_a ? OUT : IDLE;
  assign state_b_d  = rd_en_b ? OUT : IDLE;
  assign addr_err_d = (write && !(|wr_onehot)) ||
                      (rd_en_a && !(|sel_a)) ||
                      (rd_en_b && !(|sel_b));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_a_q  <= IDLE;
      state_b_q  <= IDLE;
      addr_err_q <= 1'b0;
    end else begin
      state_a_q  <= state_a_d;
      state_b_q  <= state_b_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign valid_a  = (state_a_q == OUT);
  assign valid_b  = (state_b_q == OUT);
  assign addr_err = addr_err_q;

`ifdef REGFILE_PARITY_EN
  logic perr_a_q, perr_a_d;
  logic perr_b_q, perr_b_d;

  // Only a real storage read can disagree; bypassed and out-of-range reads never flag.
  assign perr_a_d = rd_en_a && !byp_a && (|sel_a) &&
                    (rd_word_a[DATA_W] != (^rd_word_a[DATA_W-1:0]));
  assign perr_b_d = rd_en_b && !byp_b && (|sel_b) &&
                    (rd_word_b[DATA_W] != (^rd_word_b[DATA_W-1:0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_a_q <= 1'b0;
      perr_b_q <= 1'b0;
    end else begin
      perr_a_q <= perr_a_d;
      perr_b_q <= perr_b_d;
    end
  end

  assign parity_err_a = perr_a_q;
  assign parity_err_b = perr_b_q;
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        rd_en_a;
  logic [2:0]  readnum_a;
  logic        rd_en_b;
  logic [2:0]  readnum_b;

  logic [15:0] da8, db8, da6, db6;
  logic        va8, vb8, ae8, va6, vb6, ae6;
`ifdef REGFILE_PARITY_EN
  logic        pa8, pb8, pa6, pb6;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) dut8 (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .rd_en_a(rd_en_a), .readnum_a(readnum_a), .data_out_a(da8), .valid_a(va8),
    .rd_en_b(rd_en_b), .readnum_b(readnum_b), .data_out_b(db8), .valid_b(vb8),
    .addr_err(ae8)
`ifdef REGFILE_PARITY_EN
    , .parity_err_a(pa8), .parity_err_b(pb8)
`endif
  );

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .NREGS(6)) dut6 (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .rd_en_a(rd_en_a), .readnum_a(readnum_a), .data_out_a(da6), .valid_a(va6),
    .rd_en_b(rd_en_b), .readnum_b(readnum_b), .data_out_b(db6), .valid_b(vb6),
    .addr_err(ae6)
`ifdef REGFILE_PARITY_EN
    , .parity_err_a(pa6), .parity_err_b(pb6)
`endif
  );

  // Reference model: index 0 models the 8-register build, index 1 the 6-register build.
  int          nr [2] = '{8, 6};
  logic [15:0] mem  [2][8];
  logic [15:0] e_da [2];
  logic [15:0] e_db [2];
  logic        e_va [2];
  logic        e_vb [2];
  logic        e_ae [2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = nr[k];
      if (reset) begin
        for (int j = 0; j < 8; j++) mem[k][j] = 16'h0000;
        e_da[k] = 16'h0000; e_db[k] = 16'h0000;
        e_va[k] = 1'b0; e_vb[k] = 1'b0; e_ae[k] = 1'b0;
      end else begin
        if (rd_en_a)
          e_da[k] = (int'(readnum_a) >= n) ? 16'h0000 :
                    (write && writenum == readnum_a) ? data_in : mem[k][readnum_a];
        if (rd_en_b)
          e_db[k] = (int'(readnum_b) >= n) ? 16'h0000 :
                    (write && writenum == readnum_b) ? data_in : mem[k][readnum_b];
        e_va[k] = rd_en_a;
        e_vb[k] = rd_en_b;
        e_ae[k] = (write && int'(writenum) >= n) || (rd_en_a && int'(readnum_a) >= n) ||
                  (rd_en_b && int'(readnum_b) >= n);
        if (write && int'(writenum) < n) mem[k][writenum] = data_in;
      end
    end
  endtask

  // Apply current inputs for one edge, then compare both DUTs against the model.
  task automatic tick();
    model_step();
    repeat (RD_LATENCY) @(posedge clk);
    #1;
    check("d8_data_a", {16'h0, da8}, {16'h0, e_da[0]});
    check("d8_valid_a", {31'h0, va8}, {31'h0, e_va[0]});
    check("d8_data_b", {16'h0, db8}, {16'h0, e_db[0]});
    check("d8_valid_b", {31'h0, vb8}, {31'h0, e_vb[0]});
    check("d8_addr_err", {31'h0, ae8}, {31'h0, e_ae[0]});
    check("d6_data_a", {16'h0, da6}, {16'h0, e_da[1]});
    check("d6_valid_a", {31'h0, va6}, {31'h0, e_va[1]});
    check("d6_data_b", {16'h0, db6}, {16'h0, e_db[1]});
    check("d6_valid_b", {31'h0, vb6}, {31'h0, e_vb[1]});
    check("d6_addr_err", {31'h0, ae6}, {31'h0, e_ae[1]});
`ifdef REGFILE_PARITY_EN
    check("d8_perr", {30'h0, pa8, pb8}, 32'h0);
    check("d6_perr", {30'h0, pa6, pb6}, 32'h0);
`endif
  endtask

  task automatic drive(input logic rst, input logic w, input logic [2:0] wn, input logic [15:0] d,
                       input logic ra_en, input logic [2:0] ra, input logic rb_en, input logic [2:0] rb);
    reset = rst; write = w; writenum = wn; data_in = d;
    rd_en_a = ra_en; readnum_a = ra; rd_en_b = rb_en; readnum_b = rb;
    tick();
  endtask

  initial begin
    // Reset
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    // Read every address on both ports after reset
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(i));
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
    // Write R3, then read it on both ports
    drive(1'b0, 1'b1, 3'd3, 16'hABCD, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd3);
    check("r3_a_direct", {16'h0, da8}, 32'h0000ABCD);
    // Same-edge write and read of R5 (bypass), then read on B
    drive(1'b0, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 1'b0, 3'd0);
    check("bypass_direct", {16'h0, da8}, 32'h00001234);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd5);
    // Fill all registers, then stream reads 0..7 on A
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 3'(i), 16'(i * 16'h1111), 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b0, 3'd0);
    check("stream_last", {16'h0, da8}, 32'h00007777);
    // Reset kills a same-edge read
    drive(1'b0, 1'b1, 3'd2, 16'h00FF, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 3'd0);
    // Out-of-range write and read on the 6-register build
    drive(1'b0, 1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0, 3'd0);
    check("oor_err_direct", {31'h0, ae6}, 32'h1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
